// File: rtl/hazard_pkg.sv
// hazard_pkg: shared record type, default cycle constants and saturating decrement for the hazard unit
package hazard_pkg;
  localparam int DEF_REG_AW = 5;
  localparam int DEF_TW = 2;
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES = 10;
  typedef struct packed {
    logic [DEF_REG_AW-1:0] dst;
    logic [DEF_TW-1:0]     tnew;
  } sb_rec_t;
  function automatic int unsigned sat_dec(int unsigned v);
    return (v == 0) ? 0 : v - 1;
  endfunction
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decoded ID-stage operands in, stall and forward selects out
interface hazard_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int TW = 2,
  parameter int FWD_W = 2
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs_addr;
  logic [REG_AW-1:0] id_rt_addr;
  logic              id_rs_used;
  logic              id_rt_used;
  logic [TW-1:0]     id_rs_tuse;
  logic [TW-1:0]     id_rt_tuse;
  logic [REG_AW-1:0] id_dst_addr;
  logic [TW-1:0]     id_tnew;
  logic              id_md_start;
  logic              id_md_is_div;
  logic              id_md_access;
  logic              stall;
  logic [FWD_W-1:0]  fwd_rs_sel;
  logic [FWD_W-1:0]  fwd_rt_sel;
  logic              md_busy;
  modport master (
    output id_valid, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used, id_rs_tuse, id_rt_tuse,
           id_dst_addr, id_tnew, id_md_start, id_md_is_div, id_md_access,
    input  stall, fwd_rs_sel, fwd_rt_sel, md_busy
  );
  modport slave (
    input  id_valid, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used, id_rs_tuse, id_rt_tuse,
           id_dst_addr, id_tnew, id_md_start, id_md_is_div, id_md_access,
    output stall, fwd_rs_sel, fwd_rt_sel, md_busy
  );
endinterface

// File: rtl/md_busy_counter.sv
// md_busy_counter: mult/div occupancy counter; a new op reloads, otherwise it drains to zero
module md_busy_counter import hazard_pkg::*; #(
  parameter int BUSY_W = 4,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic is_div,
  output logic busy
);
  logic [BUSY_W-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= load ? (is_div ? BUSY_W'(DIV_CYCLES) : BUSY_W'(MULT_CYCLES)) : BUSY_W'(sat_dec(32'(cnt)));
  assign busy = cnt != '0;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: shift-register scoreboard of in-flight writers producing ID stall and forward selects
module hazard_scoreboard import hazard_pkg::*; #(
  parameter int NUM_STAGES = 3,
  parameter int REG_AW = DEF_REG_AW,
  parameter int TW = DEF_TW,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES,
  parameter int BUSY_W = 4,
  parameter int FWD_W = $clog2(NUM_STAGES + 1)
) (
  input logic clk,
  input logic reset,
  hazard_scoreboard_if.slave hz
);
  typedef struct packed {
    logic [REG_AW-1:0] dst;
    logic [TW-1:0]     tnew;
  } rec_t;
  rec_t [NUM_STAGES-1:0] sb;
  logic [1:0] op_stall;
  logic md_stall;
  logic md_load;
  always_ff @(posedge clk or posedge reset)
    if (reset) sb <= '0;
    else begin
      sb[0] <= hz.stall ? rec_t'('0) : rec_t'{dst: hz.id_valid ? hz.id_dst_addr : '0, tnew: hz.id_tnew};
      for (int k = 1; k < NUM_STAGES; k++)
        sb[k] <= rec_t'{dst: sb[k-1].dst, tnew: TW'(sat_dec(32'(sb[k-1].tnew)))};
    end
  // o = 0 is rs, o = 1 is rt; scanning oldest-first leaves the youngest match
  for (genvar o = 0; o < 2; o++) begin : g_op
    logic [REG_AW-1:0] addr;
    logic [TW-1:0]     tuse;
    logic              live;
    logic              hit;
    logic [FWD_W-1:0]  idx;
    logic [TW-1:0]     tn;
    logic [FWD_W-1:0]  sel;
    assign addr = (o == 0) ? hz.id_rs_addr : hz.id_rt_addr;
    assign tuse = (o == 0) ? hz.id_rs_tuse : hz.id_rt_tuse;
    assign live = hz.id_valid && ((o == 0) ? hz.id_rs_used : hz.id_rt_used) && addr != '0;
    always_comb begin
      hit = 1'b0;
      idx = '0;
      tn = '0;
      for (int k = NUM_STAGES - 1; k >= 0; k--)
        if (live && sb[k].dst == addr) begin
          hit = 1'b1;
          idx = FWD_W'(k + 1);
          tn = sb[k].tnew;
        end
    end
    assign op_stall[o] = hit && tn > tuse;
    assign sel = (hit && tn == '0) ? idx : '0;
  end
  assign hz.fwd_rs_sel = g_op[0].sel;
  assign hz.fwd_rt_sel = g_op[1].sel;
  assign md_stall = hz.id_valid && (hz.id_md_access || hz.id_md_start) && hz.md_busy;
  assign hz.stall = |op_stall || md_stall;
  assign md_load = !hz.stall && hz.id_valid && hz.id_md_start;
  md_busy_counter #(
    .BUSY_W(BUSY_W),
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) u_md (
    .clk(clk),
    .reset(reset),
    .load(md_load),
    .is_div(hz.id_md_is_div),
    .busy(hz.md_busy)
  );
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed pipeline scenarios plus random traffic against an age-based reference model
module tb_hazard_scoreboard;
  import hazard_pkg::*;
  localparam int NS = 3;
  typedef struct {
    bit v;
    int rs, rt;
    bit rsu, rtu;
    int rs_tu, rt_tu;
    int dst, tnew;
    bit ms, md, ma;
  } id_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  hazard_scoreboard_if #(.REG_AW(5), .TW(2), .FWD_W(2)) hz ();
  hazard_scoreboard #(.NUM_STAGES(NS)) dut (.clk(clk), .reset(reset), .hz(hz));
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_bad = 0;
  sb_rec_t m_sb [NS];
  int m_age [NS];
  int m_md;
  id_t cur;
  bit e_stall;
  int o_stall, o_rs, o_rt, o_md;
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic id_t op(int dst, int tnew, int rs, int rs_tu, int rt, int rt_tu);
    id_t i;
    i = '{v: 1, rs: rs, rt: rt, rsu: rs_tu >= 0, rtu: rt_tu >= 0, rs_tu: rs_tu < 0 ? 0 : rs_tu,
          rt_tu: rt_tu < 0 ? 0 : rt_tu, dst: dst, tnew: tnew, ms: 0, md: 0, ma: 0};
    return i;
  endfunction
  function automatic id_t mdop(bit start, bit div, bit acc);
    id_t i;
    i = op(0, 0, 0, -1, 0, -1);
    i.ms = start;
    i.md = div;
    i.ma = acc;
    return i;
  endfunction
  // result latency remaining = issued tnew minus cycles since E entry, floored at zero
  function automatic int eff(int k);
    int t;
    t = int'(m_sb[k].tnew) - m_age[k];
    return t < 0 ? 0 : t;
  endfunction
  task automatic expect_op(input int addr, input bit used, input int tuse, output bit st, output int sel);
    st = 0;
    sel = 0;
    if (cur.v && used && addr != 0)
      for (int k = 0; k < NS; k++)
        if (int'(m_sb[k].dst) == addr) begin
          st = eff(k) > tuse;
          sel = eff(k) == 0 ? k + 1 : 0;
          break;
        end
  endtask
  task automatic model_clear();
    for (int k = 0; k < NS; k++) begin
      m_sb[k] = '0;
      m_age[k] = 0;
    end
    m_md = 0;
  endtask
  task automatic drive(input id_t i);
    cur = i;
    hz.id_valid = i.v;
    hz.id_rs_addr = 5'(i.rs);
    hz.id_rt_addr = 5'(i.rt);
    hz.id_rs_used = i.rsu;
    hz.id_rt_used = i.rtu;
    hz.id_rs_tuse = 2'(i.rs_tu);
    hz.id_rt_tuse = 2'(i.rt_tu);
    hz.id_dst_addr = 5'(i.dst);
    hz.id_tnew = 2'(i.tnew);
    hz.id_md_start = i.ms;
    hz.id_md_is_div = i.md;
    hz.id_md_access = i.ma;
  endtask
  task automatic compare(input string tag);
    bit rs_st, rt_st, md_st;
    int rs_sel, rt_sel;
    expect_op(cur.rs, cur.rsu, cur.rs_tu, rs_st, rs_sel);
    expect_op(cur.rt, cur.rtu, cur.rt_tu, rt_st, rt_sel);
    md_st = cur.v && (cur.ma || cur.ms) && m_md > 0;
    e_stall = rs_st || rt_st || md_st;
    o_stall = int'(hz.stall);
    o_rs = int'(hz.fwd_rs_sel);
    o_rt = int'(hz.fwd_rt_sel);
    o_md = int'(hz.md_busy);
    check({tag, "_stall"}, o_stall, int'(e_stall));
    check({tag, "_rs"}, o_rs, rs_sel);
    check({tag, "_rt"}, o_rt, rt_sel);
    check({tag, "_busy"}, o_md, int'(m_md > 0));
  endtask
  task automatic step(input id_t i, input string tag);
    drive(i);
    #1;
    compare(tag);
    @(posedge clk);
    for (int k = NS - 1; k > 0; k--) begin
      m_sb[k] = m_sb[k-1];
      m_age[k] = m_age[k-1] + 1;
    end
    m_sb[0].dst = (e_stall || !cur.v) ? 5'd0 : 5'(cur.dst);
    m_sb[0].tnew = e_stall ? 2'd0 : 2'(cur.tnew);
    m_age[0] = 0;
    if (!e_stall && cur.v && cur.ms) m_md = cur.md ? 10 : 5;
    else if (m_md > 0) m_md--;
    @(negedge clk);
  endtask
  initial begin
    id_t r;
    model_clear();
    drive(mdop(0, 0, 0));
    #1;
    compare("reset");
    @(negedge clk);
    reset = 1'b0;
    step(op(8, 2, 0, -1, 0, -1), "lw");
    step(op(0, 0, 8, 0, 0, -1), "beq_a");
    check("lu_stall_a", o_stall, 1);
    step(op(0, 0, 8, 0, 0, -1), "beq_b");
    check("lu_stall_b", o_stall, 1);
    step(op(0, 0, 8, 0, 0, -1), "beq_c");
    check("lu_stall_c", o_stall, 0);
    check("lu_fwd", o_rs, 3);
    step(op(9, 1, 0, -1, 0, -1), "addu9");
    step(op(10, 1, 9, 1, 0, -1), "alu_use1");
    check("alu_nostall", o_stall, 0);
    check("alu_nofwd", o_rs, 0);
    step(op(11, 1, 9, 0, 0, -1), "alu_use0");
    check("alu_fwd2", o_rs, 2);
    step(op(5, 1, 0, -1, 0, -1), "ori5");
    step(op(5, 1, 0, -1, 0, -1), "lui5");
    step(op(0, 0, 0, -1, 5, 0), "mw_a");
    check("mw_stall", o_stall, 1);
    step(op(0, 0, 0, -1, 5, 0), "mw_b");
    check("mw_go", o_stall, 0);
    check("mw_fwd", o_rt, 2);
    step(op(0, 2, 0, -1, 0, -1), "addu0");
    step(op(0, 0, 0, 0, 0, -1), "zero");
    check("zero_stall", o_stall, 0);
    check("zero_fwd", o_rs, 0);
    step(mdop(1, 1, 0), "div");
    for (int n = 0; n < 10; n++) begin
      step(mdop(0, 0, 1), "mflo");
      check("div_stall", o_stall, 1);
    end
    step(mdop(0, 0, 1), "mflo_go");
    check("div_done", o_stall, 0);
    check("div_idle", o_md, 0);
    step(mdop(1, 0, 0), "mult");
    for (int n = 0; n < 5; n++) begin
      step(mdop(0, 0, 1), "mfhi");
      check("mult_stall", o_stall, 1);
    end
    step(mdop(0, 0, 1), "mfhi_go");
    check("mult_done", o_stall, 0);
    step(mdop(1, 0, 0), "mult_a");
    step(mdop(1, 0, 0), "mult_b");
    check("mult_busy_stall", o_stall, 1);
    for (int n = 0; n < 6; n++) step(mdop(0, 0, 0), "drain");
    step(mdop(1, 1, 0), "div_r");
    step(op(8, 2, 0, -1, 0, -1), "lw_r");
    drive(op(0, 0, 8, 0, 0, -1));
    #1;
    compare("rst_pre");
    check("rst_pre_stall", o_stall, 1);
    reset = 1'b1;
    model_clear();
    #1;
    compare("rst_in");
    check("rst_in_stall", o_stall, 0);
    check("rst_in_busy", o_md, 0);
    @(negedge clk);
    reset = 1'b0;
    step(op(0, 0, 8, 0, 0, -1), "rst_after");
    check("rst_after_stall", o_stall, 0);
    for (int n = 0; n < 2000; n++) begin
      r.v = $urandom_range(0, 7) != 0;
      r.rs = $urandom_range(0, 7);
      r.rt = $urandom_range(0, 7);
      r.rsu = $urandom_range(0, 3) != 0;
      r.rtu = $urandom_range(0, 1) != 0;
      r.rs_tu = $urandom_range(0, 3);
      r.rt_tu = $urandom_range(0, 3);
      r.dst = $urandom_range(0, 7);
      r.tnew = $urandom_range(0, 3);
      r.ms = $urandom_range(0, 15) == 0;
      r.md = $urandom_range(0, 1) != 0;
      r.ma = $urandom_range(0, 7) == 0;
      step(r, "rnd");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the per-operand Tuse decoders; the sequential hazard unit of the pipelined MIPS core.
- Tracks destination register and Tnew for every in-flight instruction past ID (E, M, W, ...) in a shift-register scoreboard.
- Combines that state with the decoded Tuse of the instruction in ID to produce stall and ID-stage forward selects.
- Also owns the mult/div busy counter that stalls HI/LO accesses.

Parameters:
- NUM_STAGES, 3, tracked stages after ID (index 0 = E); must be >= 1
- REG_AW, 5, register address width
- TW, 2, Tnew/Tuse width
- MULT_CYCLES, 5, busy cycles for mult/multu
- DIV_CYCLES, 10, busy cycles for div/divu
- BUSY_W, 4, busy counter width; must hold DIV_CYCLES
- FWD_W, $clog2(NUM_STAGES+1), forward-select width

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- id_valid  in  1  ID holds a real instruction
- id_rs_addr, id_rt_addr  in  REG_AW  source operands
- id_rs_used, id_rt_used  in  1  operand is read
- id_rs_tuse, id_rt_tuse  in  TW  cycles until operand is consumed
- id_dst_addr  in  REG_AW  destination (0 = none)
- id_tnew  in  TW  cycles after E entry until the result exists
- id_md_start  in  1  ID is mult/multu/div/divu
- id_md_is_div  in  1  qualifies id_md_start
- id_md_access  in  1  ID is mfhi/mflo/mthi/mtlo
- stall  out  1  freeze PC/IF/ID and insert a bubble into E
- fwd_rs_sel, fwd_rt_sel  out  FWD_W  0 = GRF, k+1 = result of stage k
- md_busy  out  1  busy counter nonzero

Behaviour:
- State: NUM_STAGES records {dst, tnew} plus md counter.
- Reset (async): all dst=0, tnew=0, counter=0. Outputs: stall=0, fwd_*=0, md_busy=0 while reset is high and after it deasserts.
- Every cycle record[k+1] <= {record[k].dst, sat_dec(record[k].tnew)}. Saturating decrement never drops below 0. Oldest record is discarded.
- Entry when stall=0: record[0] <= {id_valid ? id_dst_addr : 0, id_tnew}.
- Entry when stall=1: record[0] <= {0, 0} (bubble). Later stages advance regardless.
- Matching per operand: operand is live if used, id_valid and addr != 0. Its match is the youngest k with record[k].dst == addr. $0 never matches, never stalls, never forwards.
- Operand stall: live and match exists and record[k].tnew > tuse.
- fwd_sel: k+1 if match exists and record[k].tnew == 0, else 0. Outputs are combinational from state and ID inputs.
- A match with 0 < tnew <= tuse gives no stall and fwd_sel 0. Later stages forward it.
- md counter load: when stall=0, id_valid and id_md_start, counter <= id_md_is_div ? DIV_CYCLES : MULT_CYCLES.
- md counter decrement: otherwise counter <= sat_dec(counter). This happens even while stalled.
- md stall: id_valid and (id_md_access or id_md_start) and md_busy.
- stall = rs stall | rt stall | md stall.
- Simultaneous load and decrement: load wins.
- Reset mid-stall: stall drops asynchronously and the scoreboard empties.
- No flush port. Branch-delay semantics mean no squashing.

Decomposition:
- Package hazard_pkg: sb_rec_t {dst, tnew}, sat_dec function, default cycle constants.
- Sub-module md_busy_counter: load/decrement/busy logic, parametrised by BUSY_W, MULT_CYCLES, DIV_CYCLES.
- Matching loop stays in the top module as a generate/for over NUM_STAGES.

Test Plan:
- Load-use branch: lw $8 (id_tnew=2), then beq rs=$8 (tuse=0) → stall=1 for 2 cycles, then fwd_rs_sel=3, stall=0.
- ALU-ALU: addu $9 (tnew=1), then addu rs=$9 (tuse=1) → no stall, fwd_rs_sel=0. One cycle later with tuse=0 operand → fwd_rs_sel=2.
- Multiple writers: ori $5 then lui $5 back-to-back, then beq rt=$5 → match is the lui record. With the lui record at k=1, tnew=0 → fwd_rt_sel=2.
- Zero register: addu $0 (tnew=2), then beq rs=$0 tuse=0 → stall=0, fwd_rs_sel=0.
- Mult/div: div issues, then mflo → md_busy high 10 cycles, stall for 10 cycles. mult then mfhi → 5 cycles. New mult while busy → stall.
- Reset: assert reset during the lw→beq stall → stall=0 and md_busy=0 immediately. After release, beq rs=$8 → no stall.
